// File: rtl/core_mem_pkg.sv
// rtl/core_mem_pkg.sv - shared types and defaults for the unified memory port arbiter
package core_mem_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_I,
    WAIT_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  // Round-robin pick: on a tie the requester that did not win last time goes next.
  function automatic grant_t pick_grant(input logic if_req, input logic d_req,
                                        input grant_t last_grant);
    grant_t win;
    if (if_req && d_req) begin
      win = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
    end else if (d_req) begin
      win = GRANT_D;
    end else begin
      win = GRANT_I;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts un-acknowledged wait cycles of the current transaction
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  // count holds completed wait cycles; expired flags the MAX_WAIT-th one.
  assign expired = (count >= 8'(MAX_WAIT - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one memory port between fetch and data
module mem_port_arbiter
  import core_mem_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              timeout_err
);

  arb_state_t        state, state_n;
  grant_t            last_grant, last_grant_n;
  grant_t            win;
  logic              grant;
  logic              waiting;
  logic              expired;
  logic              mem_req_n, mem_we_n, if_valid_n, d_valid_n, timeout_err_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, if_rdata_n, d_rdata_n;

  assign win     = pick_grant(if_req, d_req, last_grant);
  assign waiting = ((state == WAIT_I) || (state == WAIT_D)) && !mem_ack;
  assign stall   = (if_req & ~if_valid) | (d_req & ~d_valid);

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (grant),
    .enable (waiting),
    .expired(expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= GRANT_D;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      if_valid    <= 1'b0;
      d_valid     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      mem_req     <= mem_req_n;
      mem_we      <= mem_we_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
      if_rdata    <= if_rdata_n;
      d_rdata     <= d_rdata_n;
      if_valid    <= if_valid_n;
      d_valid     <= d_valid_n;
      timeout_err <= timeout_err_n;
    end
  end

  always_comb begin
    state_n       = state;
    last_grant_n  = last_grant;
    grant         = 1'b0;
    mem_req_n     = mem_req;
    mem_we_n      = mem_we;
    mem_addr_n    = mem_addr;
    mem_wdata_n   = mem_wdata;
    if_rdata_n    = if_rdata;
    d_rdata_n     = d_rdata;
    if_valid_n    = 1'b0;
    d_valid_n     = 1'b0;
    timeout_err_n = timeout_err;

    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant        = 1'b1;
          last_grant_n = win;
          mem_req_n    = 1'b1;
          if (win == GRANT_D) begin
            state_n     = WAIT_D;
            mem_we_n    = d_we;
            mem_addr_n  = d_addr;
            mem_wdata_n = d_wdata;
          end else begin
            state_n     = WAIT_I;
            mem_we_n    = 1'b0;
            mem_addr_n  = if_addr;
            mem_wdata_n = '0;
          end
        end
      end
      WAIT_I: begin
        if (mem_ack) begin
          mem_req_n  = 1'b0;
          if_rdata_n = mem_rdata;
          if_valid_n = 1'b1;
          state_n    = RESP;
        end else if (expired) begin
          mem_req_n     = 1'b0;
          timeout_err_n = 1'b1;
          if_rdata_n    = '0;
          if_valid_n    = 1'b1;
          state_n       = RESP;
        end
      end
      WAIT_D: begin
        // Stores complete with zero load data so the datapath never sees stale bus data.
        if (mem_ack) begin
          mem_req_n = 1'b0;
          d_rdata_n = mem_we ? '0 : mem_rdata;
          d_valid_n = 1'b1;
          state_n   = RESP;
        end else if (expired) begin
          mem_req_n     = 1'b0;
          timeout_err_n = 1'b1;
          d_rdata_n     = '0;
          d_valid_n     = 1'b1;
          state_n       = RESP;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_WAIT(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_valid    (d_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stall      (stall),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    step();
    step();

    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_d_rdata", d_rdata, 32'h0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_d_valid", d_valid, 1'b0);
    chk1("rst_timeout", timeout_err, 1'b0);
    reset = 1'b0;
    step();

    // lone fetch, zero-wait ack
    if_req  = 1'b1;
    if_addr = 32'h0000_0004;
    #1;
    chk1("f_stall_c0", stall, 1'b1);
    step();
    chk1("f_mem_req_c1", mem_req, 1'b1);
    chk32("f_mem_addr_c1", mem_addr, 32'h4);
    chk1("f_mem_we_c1", mem_we, 1'b0);
    chk1("f_stall_c1", stall, 1'b1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0093;
    step();
    chk1("f_mem_req_c2", mem_req, 1'b0);
    chk1("f_if_valid_c2", if_valid, 1'b1);
    chk32("f_if_rdata_c2", if_rdata, 32'h93);
    chk1("f_stall_c2", stall, 1'b0);
    if_req  = 1'b0;
    mem_ack = 1'b0;
    step();
    chk1("f_if_valid_c3", if_valid, 1'b0);
    chk32("f_if_rdata_hold", if_rdata, 32'h93);

    // simultaneous fetch + store after reset: fetch first
    reset = 1'b1;
    step();
    reset     = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0008;
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_addr    = 32'h0000_0100;
    d_wdata   = 32'hDEAD_BEEF;
    mem_ack   = 1'b1;
    mem_rdata = 32'hAAAA_5555;
    step();
    chk1("s_mem_req_i", mem_req, 1'b1);
    chk1("s_mem_we_i", mem_we, 1'b0);
    chk32("s_mem_addr_i", mem_addr, 32'h8);
    chk32("s_mem_wdata_i", mem_wdata, 32'h0);
    step();
    chk1("s_if_valid", if_valid, 1'b1);
    chk32("s_if_rdata", if_rdata, 32'hAAAA_5555);
    chk1("s_d_valid_early", d_valid, 1'b0);
    chk1("s_stall_d_pending", stall, 1'b1);
    if_req = 1'b0;
    step();
    chk1("s_mem_req_idle", mem_req, 1'b0);
    step();
    chk1("s_mem_req_d", mem_req, 1'b1);
    chk1("s_mem_we_d", mem_we, 1'b1);
    chk32("s_mem_addr_d", mem_addr, 32'h100);
    chk32("s_mem_wdata_d", mem_wdata, 32'hDEAD_BEEF);
    step();
    chk1("s_d_valid", d_valid, 1'b1);
    chk32("s_d_rdata_store", d_rdata, 32'h0);
    d_req   = 1'b0;
    mem_ack = 1'b0;
    step();
    chk1("s_d_valid_drop", d_valid, 1'b0);

    // load with three wait cycles
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0200;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk1("w_mem_req", mem_req, 1'b1);
      chk32("w_mem_addr", mem_addr, 32'h200);
      chk1("w_d_valid_low", d_valid, 1'b0);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    step();
    chk1("w_d_valid_c5", d_valid, 1'b1);
    chk32("w_d_rdata", d_rdata, 32'h1234_5678);
    chk1("w_mem_req_c5", mem_req, 1'b0);
    chk1("w_no_timeout", timeout_err, 1'b0);
    d_req   = 1'b0;
    mem_ack = 1'b0;
    step();
    step();

    // fetch that is never acknowledged
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk1("t_mem_req", mem_req, 1'b1);
      chk1("t_if_valid_low", if_valid, 1'b0);
    end
    step();
    chk1("t_mem_req_drop", mem_req, 1'b0);
    chk1("t_if_valid", if_valid, 1'b1);
    chk32("t_if_rdata_zero", if_rdata, 32'h0);
    chk1("t_timeout_set", timeout_err, 1'b1);
    if_req = 1'b0;
    step();
    chk1("t_if_valid_drop", if_valid, 1'b0);
    step();
    chk1("t_timeout_sticky", timeout_err, 1'b1);

    // reset while waiting on a load, ack arrives afterwards
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0300;
    step();
    chk1("r_mem_req_wait", mem_req, 1'b1);
    reset = 1'b1;
    d_req = 1'b0;
    step();
    chk1("r_mem_req_rst", mem_req, 1'b0);
    chk1("r_timeout_clr", timeout_err, 1'b0);
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_FFFF;
    step();
    chk1("r_no_d_valid_a", d_valid, 1'b0);
    chk1("r_mem_req_idle", mem_req, 1'b0);
    step();
    chk1("r_no_d_valid_b", d_valid, 1'b0);
    chk32("r_d_rdata_zero", d_rdata, 32'h0);
    mem_ack = 1'b0;

    // both requesters held, ack held high (stray acks in IDLE/RESP)
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h0000_0020;
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk1("b_mem_req", mem_req, 1'b1);
      chk32("b_mem_addr", mem_addr, (k % 2 == 0) ? 32'h10 : 32'h20);
      mem_rdata = 32'h100 + 32'(k);
      step();
      chk1("b_if_valid", if_valid, (k % 2 == 0));
      chk1("b_d_valid", d_valid, (k % 2 == 1));
      if (k % 2 == 0) chk32("b_if_rdata", if_rdata, 32'h100 + 32'(k));
      else chk32("b_d_rdata", d_rdata, 32'h100 + 32'(k));
      chk1("b_mem_req_resp", mem_req, 1'b0);
      step();
      chk1("b_mem_req_idle", mem_req, 1'b0);
      chk1("b_if_valid_idle", if_valid, 1'b0);
      chk1("b_d_valid_idle", d_valid, 1'b0);
    end
    if_req  = 1'b0;
    d_req   = 1'b0;
    mem_ack = 1'b0;
    step();
    step();
    step();
    chk1("end_mem_req", mem_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
